user_input_debounce: RTL and testbench

USER_INPUT_DEBOUNCE -- requirements
Module: user_input_debounce

---
 rtl/user_input_debounce.sv | 183 ++++++++++++++++++
 tb/tb_user_input_debounce.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/user_input_debounce.sv
// -----------------------------------------------------------------------------
// user_input_debounce
//
// Debounces a raw, asynchronous, active-high pushbutton level. The input is
// first brought into the clk domain through a 2-flop synchronizer (3 flops when
// USER_INPUT_SYNC3_EN is defined). A four-state FSM then accepts a level
// change only after DEBOUNCE_CYCLES consecutive synchronized samples at the
// new level. Any sample of the old level during qualification aborts back to
// the stable state.
//
// Optional build macro:
//   USER_INPUT_SYNC3_EN  3-flop synchronizer; FSM observes s3 (one extra
//                        cycle of latency). Undefined: 2-flop, FSM observes s2.
//
// Ports:
//   clk        system clock, all state updates on rising edge
//   rst        synchronous, active-high reset
//   in         raw bouncy pushbutton level (asynchronous)
//   out        debounced level (registered)
//   busy       high while a candidate level change is being qualified
//   press_cnt  count of accepted low-to-high transitions of out, wraps 255->0
//
// State table:
//   state    | meaning
//   LOW      | stable low, out=0
//   CHK_HIGH | qualifying a rise, out=0, busy=1
//   HIGH     | stable high, out=1
//   CHK_LOW  | qualifying a fall, out=1, busy=1
// -----------------------------------------------------------------------------
module user_input_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in,
    output logic       out,
    output logic       busy,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,
        ST_CHK_HIGH = 2'd1,
        ST_HIGH     = 2'd2,
        ST_CHK_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ---------------------------------------------------------------- sync
    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic sync_obs;

`ifdef USER_INPUT_SYNC3_EN
    logic s3_q, s3_d;

    always_comb begin
        s1_d = in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign sync_obs = s3_q;
`else
    always_comb begin
        s1_d = in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign sync_obs = s2_q;
`endif

    // ---------------------------------------------------------------- FSM
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       press_cnt_q, press_cnt_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;

    // State register (also holds the registered outputs)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_LOW;
            cnt_q       <= '0;
            press_cnt_q <= 8'd0;
            out_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            press_cnt_q <= press_cnt_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_cnt_d = press_cnt_q;
        unique case (state_q)
            ST_LOW: begin
                if (sync_obs) begin
                    state_d = ST_CHK_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_CHK_HIGH: begin
                if (!sync_obs) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_HIGH;
                    cnt_d       = '0;
                    press_cnt_d = press_cnt_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_obs) begin
                    state_d = ST_CHK_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CHK_LOW: begin
                if (sync_obs) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: decoded from the next state so the registered outputs
    // line up with the state register.
    always_comb begin
        out_d  = (state_d == ST_HIGH)     || (state_d == ST_CHK_LOW);
        busy_d = (state_d == ST_CHK_HIGH) || (state_d == ST_CHK_LOW);
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign press_cnt = press_cnt_q;

endmodule

// File: tb/tb_user_input_debounce.sv
module tb_user_input_debounce;

    localparam int DC = 4;
`ifdef USER_INPUT_SYNC3_EN
    localparam int SYNC = 3;
`else
    localparam int SYNC = 2;
`endif
    // edges after the first new-level sample edge until out changes
    localparam int LAT = DC + SYNC - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in;
    logic       out;
    logic       busy;
    logic [7:0] press_cnt;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [2:0] m_pipe;
    logic       m_out;
    int         m_run;
    logic [7:0] m_press;

    always #5 clk = ~clk;

    user_input_debounce #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .out       (out),
        .busy      (busy),
        .press_cnt (press_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    // Behavioural rule: out flips once the synchronized input has disagreed
    // with it on DC consecutive edges; any agreeing sample restarts the run.
    // busy means a disagreeing run is in progress.
    task automatic model_edge(input logic in_v, input logic rst_v);
        logic seen;
        if (rst_v) begin
            m_pipe  = '0;
            m_out   = 1'b0;
            m_run   = 0;
            m_press = 8'd0;
        end else begin
            seen = m_pipe[SYNC-1];
            if (seen != m_out) begin
                m_run++;
                if (m_run == DC) begin
                    m_out = ~m_out;
                    m_run = 0;
                    if (m_out) m_press = m_press + 8'd1;
                end
            end else begin
                m_run = 0;
            end
            m_pipe = {m_pipe[1:0], in_v};
        end
    endtask

    task automatic step(input logic in_v, input logic rst_v);
        in  = in_v;
        rst = rst_v;
        model_edge(in_v, rst_v);
        @(posedge clk);
        #1;
        chk("out",   32'(out),       32'(m_out));
        chk("busy",  32'(busy),      32'(m_run > 0));
        chk("press", 32'(press_cnt), 32'(m_press));
    endtask

    initial begin
        int busy_seen;
        logic lvl;
        int len;
        logic [7:0] press0;
        in  = 1'b0;
        rst = 1'b1;
        m_pipe = '0; m_out = 1'b0; m_run = 0; m_press = 8'd0;

        // reset for 2 cycles
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_out",   32'(out),       32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_press", 32'(press_cnt), 32'd0);

        // held high from edge k: busy after k+SYNC, out after k+LAT
        for (int i = 0; i <= LAT; i++) begin
            step(1'b1, 1'b0);
            chk("lat_out",  32'(out),  32'(i == LAT));
            chk("lat_busy", 32'(busy), 32'((i >= SYNC) && (i < LAT)));
        end
        chk("lat_press", 32'(press_cnt), 32'd1);

        // back to stable low
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
        chk("low_out", 32'(out), 32'd0);

        // 2-cycle glitch high: rejected, busy exactly 2 cycles
        press0 = press_cnt;
        busy_seen = 0;
        step(1'b1, 1'b0); busy_seen += int'(busy);
        step(1'b1, 1'b0); busy_seen += int'(busy);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0);
            chk("glitch_out", 32'(out), 32'd0);
            busy_seen += int'(busy);
        end
        chk("glitch_busy_cycles", 32'(busy_seen), 32'd2);
        chk("glitch_press", 32'(press_cnt), 32'(press0));

        // to stable high, then bounce 0,1 then held low
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
        press0 = press_cnt;
        step(1'b0, 1'b0);
        chk("bounce_out0", 32'(out), 32'd1);
        step(1'b1, 1'b0);
        chk("bounce_out1", 32'(out), 32'd1);
        for (int i = 0; i <= LAT + 2; i++) begin
            step(1'b0, 1'b0);
            chk("fall_out", 32'(out), 32'(i < LAT));
        end
        chk("fall_press", 32'(press_cnt), 32'(press0));

        // 256 clean presses: count wraps to 0
        press0 = press_cnt;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
            for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
            chk("wrap_press", 32'(press_cnt), 32'(8'(press0 + 8'(p + 1))));
        end
        chk("wrap_final", 32'(press_cnt), 32'(press0));

        // reset during rise qualification, then full re-qualification
        for (int i = 0; i < SYNC + 1; i++) step(1'b1, 1'b0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        step(1'b1, 1'b1);
        chk("mid_rst_out",   32'(out),       32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_press", 32'(press_cnt), 32'd0);
        for (int i = 0; i <= LAT; i++) begin
            step(1'b1, 1'b0);
            chk("requal_out", 32'(out), 32'(i == LAT));
        end
        chk("requal_press", 32'(press_cnt), 32'd1);

        // randomized bouncy segments with occasional resets
        lvl = 1'b0;
        for (int s = 0; s < 2500; s++) begin
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++)
                step(lvl, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
